// File: rtl/exu_fpu_wb_ctl_if.sv
// FPU writeback bundle: issue tagging, FPU result return, FP/int writeback ports and fflags CSR access.
// The pipeline side drives through master; the writeback controller consumes through slave.
interface exu_fpu_wb_ctl_if;
  logic        issue_valid;
  logic        issue_ready;
  logic [4:0]  issue_rd;
  logic        issue_int_dst;
  logic        fpu_finish;
  logic [31:0] fpu_out;
  logic [4:0]  fpu_fflags;
  logic        flush_lower;
  logic        fp_wen;
  logic [4:0]  fp_waddr;
  logic [31:0] fp_wdata;
  logic        int_wb_valid;
  logic [4:0]  int_wb_rd;
  logic [31:0] int_wb_data;
  logic        int_wb_ready;
  logic        csr_fflags_wen;
  logic [4:0]  csr_fflags_wdata;
  logic [4:0]  fcsr_fflags;
  logic        wb_busy;

  modport master (
    output issue_valid, issue_rd, issue_int_dst, fpu_finish, fpu_out, fpu_fflags,
           flush_lower, int_wb_ready, csr_fflags_wen, csr_fflags_wdata,
    input  issue_ready, fp_wen, fp_waddr, fp_wdata, int_wb_valid, int_wb_rd,
           int_wb_data, fcsr_fflags, wb_busy
  );

  modport slave (
    input  issue_valid, issue_rd, issue_int_dst, fpu_finish, fpu_out, fpu_fflags,
           flush_lower, int_wb_ready, csr_fflags_wen, csr_fflags_wdata,
    output issue_ready, fp_wen, fp_waddr, fp_wdata, int_wb_valid, int_wb_rd,
           int_wb_data, fcsr_fflags, wb_busy
  );
endinterface

// File: rtl/exu_fpu_wb_ctl.sv
// FPU writeback/retire: tags issued ops, queues finished results in order, owns sticky fflags.
// Latency: finish -> write enable next cycle; backpressure: int head waits for int_wb_ready, issue stalls when pending or full.
module exu_fpu_wb_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst_l,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_dat,
  input  logic                         pop,
  output logic [WIDTH-1:0]             head_dat,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;

  // Storage is reset so the head-driven outputs read as zero out of reset.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        mem[wptr] <= push_dat;
        wptr      <= wptr + AW'(1);
      end
      if (pop) rptr <= rptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign head_dat = mem[rptr];
endmodule

module exu_fpu_wb_ctl #(
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_l,
  exu_fpu_wb_ctl_if.slave  bus
);
  localparam int CW = $clog2(DEPTH+1);

  typedef struct packed {
    logic [4:0]  rd;
    logic        int_dst;
    logic [31:0] data;
    logic [4:0]  fflags;
  } wb_entry_t;

  logic            pend_v;
  logic [4:0]      pend_rd;
  logic            pend_int;
  logic [CW-1:0]   count;
  wb_entry_t       head;
  wb_entry_t       push_ent;
  logic [4:0]      fflags;
  logic            issue_fire;
  logic            push;
  logic            pop;
  logic            empty;

  assign empty       = (count == '0);
  assign bus.issue_ready = ~pend_v & (count < CW'(DEPTH));
  assign issue_fire  = bus.issue_valid & bus.issue_ready & ~bus.flush_lower;
  assign push        = bus.fpu_finish & pend_v & ~bus.flush_lower;

  assign push_ent.rd      = pend_rd;
  assign push_ent.int_dst = pend_int;
  assign push_ent.data    = bus.fpu_out;
  assign push_ent.fflags  = bus.fpu_fflags;

  // A new issue can only be accepted with nothing pending, so it never races the clear.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      pend_v   <= 1'b0;
      pend_rd  <= '0;
      pend_int <= 1'b0;
    end else if (issue_fire) begin
      pend_v   <= 1'b1;
      pend_rd  <= bus.issue_rd;
      pend_int <= bus.issue_int_dst;
    end else if (bus.fpu_finish || bus.flush_lower) begin
      pend_v   <= 1'b0;
    end
  end

  exu_fpu_wb_fifo #(
    .WIDTH ($bits(wb_entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_l    (rst_l),
    .push     (push),
    .push_dat (push_ent),
    .pop      (pop),
    .head_dat (head),
    .count    (count)
  );

  assign bus.fp_wen       = ~empty & ~head.int_dst;
  assign bus.int_wb_valid = ~empty &  head.int_dst;
  assign pop              = bus.fp_wen | (bus.int_wb_valid & bus.int_wb_ready);
  assign bus.fp_waddr     = head.rd;
  assign bus.fp_wdata     = head.data;
  assign bus.int_wb_rd    = head.rd;
  assign bus.int_wb_data  = head.data;

  // Retiring flags are ORed after the CSR write so a coincident write cannot lose them.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) fflags <= '0;
    else        fflags <= (bus.csr_fflags_wen ? bus.csr_fflags_wdata : fflags)
                          | (pop ? head.fflags : 5'b0);
  end

  assign bus.fcsr_fflags = fflags;
  assign bus.wb_busy     = pend_v | ~empty;
endmodule

// File: tb/tb_exu_fpu_wb_ctl.sv
// Directed bench for exu_fpu_wb_ctl: FP/int drain, backpressure, full queue, flags, flush, async reset.
module tb_exu_fpu_wb_ctl;
  logic clk;
  logic rst_l;
  int   errors;
  int   checks;

  exu_fpu_wb_ctl_if bus();

  exu_fpu_wb_ctl #(.DEPTH(2)) dut (
    .clk   (clk),
    .rst_l (rst_l),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.issue_valid      = 1'b0;
    bus.issue_rd         = 5'd0;
    bus.issue_int_dst    = 1'b0;
    bus.fpu_finish       = 1'b0;
    bus.fpu_out          = 32'd0;
    bus.fpu_fflags       = 5'd0;
    bus.flush_lower      = 1'b0;
    bus.int_wb_ready     = 1'b0;
    bus.csr_fflags_wen   = 1'b0;
    bus.csr_fflags_wdata = 5'd0;
  endtask

  task automatic issue(input logic [4:0] rd, input logic int_dst);
    bus.issue_valid = 1'b1; bus.issue_rd = rd; bus.issue_int_dst = int_dst;
    step();
    bus.issue_valid = 1'b0;
  endtask

  task automatic finish(input logic [31:0] res, input logic [4:0] fl);
    bus.fpu_finish = 1'b1; bus.fpu_out = res; bus.fpu_fflags = fl;
    step();
    bus.fpu_finish = 1'b0; bus.fpu_out = 32'd0; bus.fpu_fflags = 5'd0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_l = 1'b0;
    #12;
    checks++; if (bus.issue_ready !== 1'b1) begin errors++; $display("FAIL reset_issue_ready got=%0b exp=1", bus.issue_ready); end
    checks++; if ({bus.fp_wen, bus.int_wb_valid, bus.wb_busy} !== 3'b000) begin errors++; $display("FAIL reset_enables got=%03b exp=000", {bus.fp_wen, bus.int_wb_valid, bus.wb_busy}); end
    checks++; if (bus.fcsr_fflags !== 5'h00) begin errors++; $display("FAIL reset_fflags got=%0h exp=0", bus.fcsr_fflags); end
    checks++; if ({bus.fp_waddr, bus.fp_wdata, bus.int_wb_rd, bus.int_wb_data} !== 74'd0) begin errors++; $display("FAIL reset_data got=%0h exp=0", {bus.fp_waddr, bus.fp_wdata, bus.int_wb_rd, bus.int_wb_data}); end
    rst_l = 1'b1;
    step();
  endtask

  task automatic test_fp_path();
    issue(5'd3, 1'b0);
    checks++; if ({bus.issue_ready, bus.wb_busy, bus.fp_wen} !== 3'b010) begin errors++; $display("FAIL fp_pending got=%03b exp=010", {bus.issue_ready, bus.wb_busy, bus.fp_wen}); end
    finish(32'h3F80_0000, 5'h00);
    checks++; if ({bus.fp_wen, bus.fp_waddr} !== {1'b1, 5'd3}) begin errors++; $display("FAIL fp_write got=%0b/%0d exp=1/3", bus.fp_wen, bus.fp_waddr); end
    checks++; if (bus.fp_wdata !== 32'h3F80_0000) begin errors++; $display("FAIL fp_wdata got=%08h exp=3f800000", bus.fp_wdata); end
    checks++; if (bus.issue_ready !== 1'b1) begin errors++; $display("FAIL fp_ready_after_finish got=%0b exp=1", bus.issue_ready); end
    step();
    checks++; if ({bus.fp_wen, bus.wb_busy} !== 2'b00) begin errors++; $display("FAIL fp_drained got=%02b exp=00", {bus.fp_wen, bus.wb_busy}); end
  endtask

  task automatic test_int_backpressure();
    bus.int_wb_ready = 1'b0;
    issue(5'd10, 1'b1);
    finish(32'h0000_0001, 5'h00);
    for (int c = 0; c < 4; c++) begin
      checks++; if ({bus.int_wb_valid, bus.int_wb_rd, bus.fp_wen} !== {1'b1, 5'd10, 1'b0}) begin errors++; $display("FAIL int_hold_c%0d got=%0b/%0d/%0b exp=1/10/0", c, bus.int_wb_valid, bus.int_wb_rd, bus.fp_wen); end
      if (c == 0) begin
        checks++; if (bus.int_wb_data !== 32'h1) begin errors++; $display("FAIL int_data got=%08h exp=1", bus.int_wb_data); end
        bus.issue_valid = 1'b1; bus.issue_rd = 5'd4; bus.issue_int_dst = 1'b0;
      end else if (c == 1) begin
        bus.issue_valid = 1'b0;
        bus.fpu_finish = 1'b1; bus.fpu_out = 32'h4000_0000;
      end else begin
        bus.fpu_finish = 1'b0;
      end
      if (c == 3) bus.int_wb_ready = 1'b1;
      step();
    end
    checks++; if ({bus.int_wb_valid, bus.fp_wen, bus.fp_waddr} !== {1'b0, 1'b1, 5'd4}) begin errors++; $display("FAIL fp_after_int got=%0b/%0b/%0d exp=0/1/4", bus.int_wb_valid, bus.fp_wen, bus.fp_waddr); end
    checks++; if (bus.fp_wdata !== 32'h4000_0000) begin errors++; $display("FAIL fp_after_int_data got=%08h exp=40000000", bus.fp_wdata); end
    step();
    checks++; if (bus.wb_busy !== 1'b0) begin errors++; $display("FAIL int_drained got=%0b exp=0", bus.wb_busy); end
    bus.int_wb_ready = 1'b0;
  endtask

  task automatic test_full_queue();
    bus.int_wb_ready = 1'b0;
    issue(5'd1, 1'b1);
    finish(32'h11, 5'h00);
    issue(5'd2, 1'b1);
    finish(32'h22, 5'h00);
    checks++; if (bus.issue_ready !== 1'b0) begin errors++; $display("FAIL full_ready got=%0b exp=0", bus.issue_ready); end
    checks++; if ({bus.int_wb_rd, bus.int_wb_data} !== {5'd1, 32'h11}) begin errors++; $display("FAIL full_head got=%0d/%0h exp=1/11", bus.int_wb_rd, bus.int_wb_data); end
    bus.int_wb_ready = 1'b1;
    step();
    bus.int_wb_ready = 1'b0;
    checks++; if ({bus.issue_ready, bus.int_wb_rd} !== {1'b1, 5'd2}) begin errors++; $display("FAIL grant_one got=%0b/%0d exp=1/2", bus.issue_ready, bus.int_wb_rd); end
    bus.int_wb_ready = 1'b1;
    step();
    bus.int_wb_ready = 1'b0;
    checks++; if (bus.wb_busy !== 1'b0) begin errors++; $display("FAIL full_drained got=%0b exp=0", bus.wb_busy); end
    for (int i = 0; i < 5; i++) begin
      issue(5'(20 + i), 1'b0);
      finish(32'hA0 + 32'(i) * 32'h101, 5'h00);
      checks++; if ({bus.fp_wen, bus.fp_waddr, bus.fp_wdata} !== {1'b1, 5'(20 + i), 32'hA0 + 32'(i) * 32'h101}) begin errors++; $display("FAIL wrap_op%0d got=%0b/%0d/%0h", i, bus.fp_wen, bus.fp_waddr, bus.fp_wdata); end
    end
    step();
    checks++; if (bus.wb_busy !== 1'b0) begin errors++; $display("FAIL wrap_drained got=%0b exp=0", bus.wb_busy); end
  endtask

  task automatic test_flags();
    issue(5'd1, 1'b0);
    finish(32'h0, 5'h01);
    step();
    checks++; if (bus.fcsr_fflags !== 5'h01) begin errors++; $display("FAIL flags_nx got=%0h exp=1", bus.fcsr_fflags); end
    issue(5'd2, 1'b0);
    finish(32'h0, 5'h05);
    step();
    checks++; if (bus.fcsr_fflags !== 5'h05) begin errors++; $display("FAIL flags_of_nx got=%0h exp=5", bus.fcsr_fflags); end
    issue(5'd3, 1'b0);
    finish(32'h0, 5'h10);
    bus.csr_fflags_wen = 1'b1; bus.csr_fflags_wdata = 5'h00;
    step();
    bus.csr_fflags_wen = 1'b0;
    checks++; if (bus.fcsr_fflags !== 5'h10) begin errors++; $display("FAIL flags_csr_retire got=%0h exp=10", bus.fcsr_fflags); end
  endtask

  task automatic test_flush();
    issue(5'd7, 1'b0);
    bus.flush_lower = 1'b1;
    step();
    bus.flush_lower = 1'b0;
    checks++; if ({bus.issue_ready, bus.wb_busy} !== 2'b10) begin errors++; $display("FAIL flush_clear got=%02b exp=10", {bus.issue_ready, bus.wb_busy}); end
    finish(32'hDEAD_BEEF, 5'h0F);
    checks++; if ({bus.fp_wen, bus.wb_busy} !== 2'b00) begin errors++; $display("FAIL flush_drop got=%02b exp=00", {bus.fp_wen, bus.wb_busy}); end
    step();
    checks++; if (bus.fcsr_fflags !== 5'h10) begin errors++; $display("FAIL flush_flags got=%0h exp=10", bus.fcsr_fflags); end
    bus.flush_lower = 1'b1;
    issue(5'd8, 1'b0);
    bus.flush_lower = 1'b0;
    checks++; if ({bus.issue_ready, bus.wb_busy} !== 2'b10) begin errors++; $display("FAIL issue_with_flush got=%02b exp=10", {bus.issue_ready, bus.wb_busy}); end
  endtask

  task automatic test_reset_mid_queue();
    bus.int_wb_ready = 1'b0;
    issue(5'd5, 1'b1);
    finish(32'h55, 5'h00);
    issue(5'd6, 1'b1);
    bus.csr_fflags_wen = 1'b1; bus.csr_fflags_wdata = 5'h1F;
    finish(32'h66, 5'h00);
    bus.csr_fflags_wen = 1'b0;
    checks++; if ({bus.int_wb_valid, bus.fcsr_fflags, bus.issue_ready} !== {1'b1, 5'h1F, 1'b0}) begin errors++; $display("FAIL pre_reset got=%0b/%0h/%0b exp=1/1f/0", bus.int_wb_valid, bus.fcsr_fflags, bus.issue_ready); end
    #2;
    rst_l = 1'b0;
    #1;
    checks++; if ({bus.issue_ready, bus.int_wb_valid, bus.wb_busy, bus.fcsr_fflags} !== {1'b1, 1'b0, 1'b0, 5'h00}) begin errors++; $display("FAIL async_reset got=%0b/%0b/%0b/%0h exp=1/0/0/0", bus.issue_ready, bus.int_wb_valid, bus.wb_busy, bus.fcsr_fflags); end
    checks++; if ({bus.int_wb_rd, bus.int_wb_data} !== 37'd0) begin errors++; $display("FAIL async_reset_data got=%0d/%0h exp=0/0", bus.int_wb_rd, bus.int_wb_data); end
    #3;
    rst_l = 1'b1;
    bus.int_wb_ready = 1'b1;
    step();
    checks++; if ({bus.int_wb_valid, bus.fp_wen, bus.wb_busy} !== 3'b000) begin errors++; $display("FAIL post_reset_empty got=%03b exp=000", {bus.int_wb_valid, bus.fp_wen, bus.wb_busy}); end
    bus.int_wb_ready = 1'b0;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_fp_path();
    test_int_backpressure();
    test_full_queue();
    test_flags();
    test_flush();
    test_reset_mid_queue();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
